// File: rtl/wb_stage.sv
// MiniMIPS32 write-back stage: load extraction/extension, 32x32 GPR file and HI/LO
// pair with same-cycle write-through bypass to the ID and EXE readers.
module wb_stage (
  input  logic        cpu_clk_50M,
  input  logic        cpu_rst_n,
  input  logic [7:0]  wb_aluop,
  input  logic [4:0]  wb_wa,
  input  logic        wb_wreg,
  input  logic        wb_whilo,
  input  logic        wb_mreg,
  input  logic [31:0] wb_dreg,
  input  logic [63:0] wb_dhilo,
  input  logic [3:0]  wb_dre,
  input  logic [31:0] dm_rdata,
  input  logic        re1,
  input  logic [4:0]  ra1,
  input  logic        re2,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic [31:0] wb_wd
);

  localparam logic [7:0]  MINIMIPS32_LB  = 8'h90;
  localparam logic [7:0]  MINIMIPS32_LBU = 8'h91;
  localparam logic [7:0]  MINIMIPS32_LH  = 8'h92;
  localparam logic [7:0]  MINIMIPS32_LHU = 8'h93;
  localparam logic [7:0]  MINIMIPS32_LW  = 8'h94;
  localparam logic        RST_ENABLE     = 1'b0;
  localparam logic [31:0] ZERO_WORD      = 32'h0000_0000;

  logic [31:0] regs [0:31];
  logic [31:0] hi;
  logic [31:0] lo;
  logic        in_rst;

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
    logic signed [7:0]  sb;
    logic signed [31:0] sw;
    sb = b;
    sw = sb;
    return sgn ? sw : {24'd0, b};
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
    logic signed [15:0] sh;
    logic signed [31:0] sw;
    sh = h;
    sw = sh;
    return sgn ? sw : {16'd0, h};
  endfunction

  // Byte lanes sign-extend only for LB/LH; every other opcode zero-extends.
  function automatic logic [31:0] load_extract(input logic [7:0] op, input logic [3:0] dre,
                                               input logic [31:0] word);
    logic sb;
    logic sh;
    sb = (op == MINIMIPS32_LB);
    sh = (op == MINIMIPS32_LH);
    case (dre)
      4'b0001: return ext_byte(word[7:0], sb);
      4'b0010: return ext_byte(word[15:8], sb);
      4'b0100: return ext_byte(word[23:16], sb);
      4'b1000: return ext_byte(word[31:24], sb);
      4'b0011: return ext_half(word[15:0], sh);
      4'b1100: return ext_half(word[31:16], sh);
      4'b1111: return word;
      default: return ZERO_WORD;
    endcase
  endfunction

  assign in_rst = (cpu_rst_n == RST_ENABLE);
  assign wb_wd  = wb_mreg ? load_extract(wb_aluop, wb_dre, dm_rdata) : wb_dreg;

  // Architectural state: reset wins over any write presented in the same cycle.
  always_ff @(posedge cpu_clk_50M) begin
    if (in_rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= ZERO_WORD;
      hi <= ZERO_WORD;
      lo <= ZERO_WORD;
    end else begin
      if (wb_wreg && (wb_wa != 5'd0)) regs[wb_wa] <= wb_wd;
      if (wb_whilo) begin
        hi <= wb_dhilo[63:32];
        lo <= wb_dhilo[31:0];
      end
    end
  end

  always_comb begin
    rd1 = ZERO_WORD;
    if (!in_rst && re1 && (ra1 != 5'd0)) begin
      if (wb_wreg && (wb_wa == ra1)) rd1 = wb_wd;
      else                           rd1 = regs[ra1];
    end
  end

  always_comb begin
    rd2 = ZERO_WORD;
    if (!in_rst && re2 && (ra2 != 5'd0)) begin
      if (wb_wreg && (wb_wa == ra2)) rd2 = wb_wd;
      else                           rd2 = regs[ra2];
    end
  end

  always_comb begin
    hi_o = ZERO_WORD;
    lo_o = ZERO_WORD;
    if (!in_rst) begin
      hi_o = wb_whilo ? wb_dhilo[63:32] : hi;
      lo_o = wb_whilo ? wb_dhilo[31:0]  : lo;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed vectors with literal expectations plus a
// per-cycle comparison against an abstract register-file model.
module tb_wb_stage;

  localparam logic [7:0] LB  = 8'h90;
  localparam logic [7:0] LBU = 8'h91;
  localparam logic [7:0] LH  = 8'h92;
  localparam logic [7:0] LHU = 8'h93;
  localparam logic [7:0] LW  = 8'h94;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  aluop;
  logic [4:0]  wa;
  logic        wreg, whilo, mreg;
  logic [31:0] dreg;
  logic [63:0] dhilo;
  logic [3:0]  dre;
  logic [31:0] rdata;
  logic        re1, re2;
  logic [4:0]  ra1, ra2;
  logic [31:0] rd1, rd2, hi_o, lo_o, wd;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_regs [0:31];
  logic [31:0] m_hi, m_lo;
  logic        m_valid = 1'b0;

  wb_stage dut (
    .cpu_clk_50M(clk), .cpu_rst_n(rst_n), .wb_aluop(aluop), .wb_wa(wa),
    .wb_wreg(wreg), .wb_whilo(whilo), .wb_mreg(mreg), .wb_dreg(dreg),
    .wb_dhilo(dhilo), .wb_dre(dre), .dm_rdata(rdata), .re1(re1), .ra1(ra1),
    .re2(re2), .ra2(ra2), .rd1(rd1), .rd2(rd2), .hi_o(hi_o), .lo_o(lo_o),
    .wb_wd(wd)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Load result from lane arithmetic: shift the selected field down, then wrap negative.
  function automatic logic [31:0] m_wd();
    int unsigned v;
    if (!mreg) return dreg;
    case (dre)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: begin
        v = (rdata >> (8 * $clog2(dre))) & 32'hFF;
        if (aluop == LB && v >= 128) v = v - 256;
        return v;
      end
      4'b0011, 4'b1100: begin
        v = (rdata >> (dre == 4'b1100 ? 16 : 0)) & 32'hFFFF;
        if (aluop == LH && v >= 32768) v = v - 65536;
        return v;
      end
      4'b1111: return rdata;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_rd(input logic re, input logic [4:0] ra);
    if (!rst_n || !re || ra == 0) return 32'd0;
    if (wreg && wa == ra) return m_wd();
    return m_regs[ra];
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_hi = 0;
      m_lo = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (wreg && wa != 0) m_regs[wa] = m_wd();
      if (whilo) begin
        m_hi = dhilo[63:32];
        m_lo = dhilo[31:0];
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("cyc_rd1", rd1, m_rd(re1, ra1));
      check("cyc_rd2", rd2, m_rd(re2, ra2));
      check("cyc_hi", hi_o, !rst_n ? 32'd0 : (whilo ? dhilo[63:32] : m_hi));
      check("cyc_lo", lo_o, !rst_n ? 32'd0 : (whilo ? dhilo[31:0] : m_lo));
    end
    check("cyc_wd", wd, m_wd());
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    aluop = 8'h21; wa = 0; wreg = 0; whilo = 0; mreg = 0; dreg = 0;
    dhilo = 0; dre = 0; rdata = 0;
  endtask

  initial begin
    logic [7:0] ops [0:5];
    logic [3:0] dres [0:8];
    ops  = '{LB, LBU, LH, LHU, LW, 8'h21};
    dres = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111, 4'b0000, 4'b0110};
    idle();
    rst_n = 0; re1 = 0; re2 = 0; ra1 = 0; ra2 = 0;
    step(); step();
    rst_n = 1;

    // Load state, confirm it, then reset with a competing write.
    wreg = 1; wa = 5; dreg = 32'hAAAA5555;
    whilo = 1; dhilo = 64'h11112222_33334444;
    step();
    idle(); re1 = 1; ra1 = 5; #2;
    check("pre_rst_x5", rd1, 32'hAAAA5555);
    check("pre_rst_hi", hi_o, 32'h11112222);
    rst_n = 0; wreg = 1; wa = 5; dreg = 32'h1234; #2;
    check("in_rst_rd1", rd1, 32'h0);
    check("in_rst_hi", hi_o, 32'h0);
    step();
    rst_n = 1; idle(); #2;
    check("post_rst_rd1", rd1, 32'h0);
    check("post_rst_hi", hi_o, 32'h0);
    check("post_rst_lo", lo_o, 32'h0);

    // Load extraction.
    mreg = 1; rdata = 32'h80F17F02;
    aluop = LB;  dre = 4'b1000; #2; check("lb_1000", wd, 32'hFFFFFF80);
    aluop = LBU; dre = 4'b0010; #2; check("lbu_0010", wd, 32'h0000007F);
    aluop = LH;  dre = 4'b1100; #2; check("lh_1100", wd, 32'hFFFF80F1);
    aluop = LHU; dre = 4'b0011; #2; check("lhu_0011", wd, 32'h00007F02);
    aluop = LW;  dre = 4'b1111; #2; check("lw_1111", wd, 32'h80F17F02);
    aluop = LB;  dre = 4'b0100; #2; check("lb_0100", wd, 32'hFFFFFFF1);
    aluop = LW;  dre = 4'b0101; #2; check("bad_dre", wd, 32'h0);
    aluop = LW;  dre = 4'b0000; #2; check("dre_0000", wd, 32'h0);
    step();

    // GPR bypass, then stored value.
    idle(); wreg = 1; wa = 7; dreg = 32'hDEADBEEF;
    re1 = 1; re2 = 1; ra1 = 7; ra2 = 7; #2;
    check("byp_rd1", rd1, 32'hDEADBEEF);
    check("byp_rd2", rd2, 32'hDEADBEEF);
    step();
    wreg = 0; #2;
    check("held_rd1", rd1, 32'hDEADBEEF);
    check("held_rd2", rd2, 32'hDEADBEEF);

    // Register 0 stays zero.
    wreg = 1; wa = 0; dreg = 32'hFFFFFFFF; ra1 = 0; #2;
    check("r0_same", rd1, 32'h0);
    step();
    wreg = 0; #2;
    check("r0_after", rd1, 32'h0);

    // Read disable.
    re2 = 0; ra2 = 7; ra1 = 7; #2;
    check("re2_off", rd2, 32'h0);
    check("re1_on", rd1, 32'hDEADBEEF);
    re2 = 1;

    // HI/LO with a concurrent GPR write.
    whilo = 1; dhilo = 64'h00000001_00000002; wreg = 1; wa = 3; dreg = 32'h33; #2;
    check("hilo_byp_hi", hi_o, 32'h1);
    check("hilo_byp_lo", lo_o, 32'h2);
    step();
    idle(); ra1 = 3; #2;
    check("hilo_hold_hi", hi_o, 32'h1);
    check("hilo_hold_lo", lo_o, 32'h2);
    check("x3_commit", rd1, 32'h33);

    // Mixed traffic checked by the per-cycle model.
    for (int k = 0; k < 60; k++) begin
      aluop = ops[$urandom_range(0, 5)];
      dre   = dres[$urandom_range(0, 8)];
      mreg  = 1'($urandom);
      wreg  = 1'($urandom);
      whilo = ($urandom_range(0, 3) == 0);
      wa    = 5'($urandom_range(0, 7));
      dreg  = $urandom;
      rdata = $urandom;
      dhilo = {$urandom, $urandom};
      re1   = ($urandom_range(0, 7) != 0);
      re2   = ($urandom_range(0, 7) != 0);
      ra1   = 5'($urandom_range(0, 7));
      ra2   = 5'($urandom_range(0, 7));
      step();
    end
    idle();
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
